// File: rtl/wide_add_pkg.sv
// Shared definitions for the wide adder sequencer: slice width, FSM encoding
// and the chunk-counter width helper.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single chunk still needs a 1-bit counter so the register is never zero-width.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/carry_select_adder_16.sv
// 16-bit carry-select adder slice: ripple low byte, precompute the high byte
// for both possible carries and select with the low byte's carry-out.
module carry_select_adder_16
  import wide_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int H = SLICE_W / 2;

  logic [H:0] w_lo;
  logic [H:0] w_hi0;
  logic [H:0] w_hi1;

  assign w_lo  = {1'b0, a[H-1:0]} + {1'b0, b[H-1:0]} + {{H{1'b0}}, cin};
  assign w_hi0 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]};
  assign w_hi1 = {1'b0, a[SLICE_W-1:H]} + {1'b0, b[SLICE_W-1:H]} + {{H{1'b0}}, 1'b1};

  assign sum  = {(w_lo[H] ? w_hi1[H-1:0] : w_hi0[H-1:0]), w_lo[H-1:0]};
  assign cout = w_lo[H] ? w_hi1[H] : w_hi0[H];

endmodule

// File: rtl/wide_add_sequencer.sv
// Round-robin shared wide adder: grants one of two requesters, then walks the
// 16-bit slice over WIDTH/16 cycles LSB chunk first with a registered carry.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic [CW-1:0]      r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               r_id;
  logic               r_valid;
  logic               r_busy;
  logic               r_last_grant;

  logic               w_grant;
  logic               w_accept;
  logic [SLICE_W-1:0] w_a_chunk;
  logic [SLICE_W-1:0] w_b_chunk;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
    else if (req1_valid)          w_grant = 1'b1;
  end

  assign req0_ready = (r_state == IDLE) && req0_valid && !w_grant;
  assign req1_ready = (r_state == IDLE) && req1_valid &&  w_grant;
  assign w_accept   = req0_ready || req1_ready;

  assign w_a_chunk = r_a[r_cnt*SLICE_W +: SLICE_W];
  assign w_b_chunk = r_b[r_cnt*SLICE_W +: SLICE_W];

  carry_select_adder_16 u_slice (
    .a    (w_a_chunk),
    .b    (w_b_chunk),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_sum        <= '0;
      r_cnt        <= '0;
      r_carry      <= 1'b0;
      r_cout       <= 1'b0;
      r_id         <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a          <= w_grant ? req1_a   : req0_a;
            r_b          <= w_grant ? req1_b   : req0_b;
            r_carry      <= w_grant ? req1_cin : req0_cin;
            r_cnt        <= '0;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          r_sum[r_cnt*SLICE_W +: SLICE_W] <= w_slice_sum;
          r_carry <= w_slice_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout  <= w_slice_cout;
            r_valid <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_id    = r_id;
  assign busy      = r_busy;

endmodule
